// File: rtl/multi_grant_selector_pkg.sv
// Shared definitions for the free-list grant selector: machine sizes and helpers.
package multi_grant_selector_pkg;

   // Grants handed out per cycle (superscalar width)
   localparam int unsigned N                = 3;
   // Physical register file size and its index width
   localparam int unsigned PHYS_REG_SZ_R10K = 64;
   localparam int unsigned PHYS_REG_ID_BITS = $clog2(PHYS_REG_SZ_R10K);

   typedef logic [PHYS_REG_ID_BITS-1:0] PHYS_REG_IDX;

   // Index width for a vector of the given width; never narrower than one bit
   function automatic int unsigned index_bits(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/onehot_to_index.sv
// One-hot to binary encoder built as an OR of the positions of all set bits.
// Exact for one-hot input; all-zero input encodes to 0.
module onehot_to_index
   import multi_grant_selector_pkg::*;
#(
   parameter int unsigned WIDTH    = PHYS_REG_SZ_R10K,
   parameter int unsigned IDX_BITS = index_bits(WIDTH)
) (
   input  logic [WIDTH-1:0]    onehot,
   output logic [IDX_BITS-1:0] index
);

   // OR together the position of every set bit
   always_comb begin
      index = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (onehot[i]) begin
            index = index | IDX_BITS'(i);
         end
      end
   end

endmodule

// File: rtl/multi_grant_selector.sv
// Picks up to REQS set bits of req, lowest index first, and reports each pick as a
// one-hot grant and a binary index. Index and valid are also registered once.
module multi_grant_selector
   import multi_grant_selector_pkg::*;
#(
   parameter int unsigned WIDTH    = PHYS_REG_SZ_R10K,
   parameter int unsigned REQS     = N,
   // Derived from WIDTH; not meant to be overridden
   parameter int unsigned IDX_BITS = index_bits(WIDTH)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [WIDTH-1:0]               req,
   output logic [WIDTH-1:0]               gnt,
   output logic [REQS-1:0][WIDTH-1:0]     gnt_bus,
   output logic [REQS-1:0][IDX_BITS-1:0]  gnt_idx,
   output logic [REQS-1:0]                gnt_valid,
   output logic                           empty,
   output logic [REQS-1:0][IDX_BITS-1:0]  gnt_idx_q,
   output logic [REQS-1:0]                gnt_valid_q
);

   if (REQS < 1 || REQS > WIDTH) begin : g_bad_params
      $error("multi_grant_selector: REQS must be in 1..WIDTH");
   end

   // Requests still unclaimed when entering each stage
   logic [REQS-1:0][WIDTH-1:0] remaining;

   assign remaining[0] = req;

   for (genvar k = 0; k < REQS; k++) begin : g_stage
      // Isolate the lowest set bit of what earlier stages left over
      assign gnt_bus[k]   = remaining[k] & (~remaining[k] + WIDTH'(1));
      assign gnt_valid[k] = |gnt_bus[k];

      if (k < REQS - 1) begin : g_pass
         assign remaining[k+1] = remaining[k] & ~gnt_bus[k];
      end

      onehot_to_index #(
         .WIDTH    (WIDTH),
         .IDX_BITS (IDX_BITS)
      ) u_enc (
         .onehot (gnt_bus[k]),
         .index  (gnt_idx[k])
      );
   end

   // Merge all slot grants into one vector
   always_comb begin
      gnt = '0;
      for (int unsigned k = 0; k < REQS; k++) begin
         gnt = gnt | gnt_bus[k];
      end
   end

   assign empty = ~|req;

   // Register index and valid every cycle for timing-critical consumers
   always_ff @(posedge clock) begin
      if (reset) begin
         gnt_idx_q   <= '0;
         gnt_valid_q <= '0;
      end else begin
         gnt_idx_q   <= gnt_idx;
         gnt_valid_q <= gnt_valid;
      end
   end

endmodule

// File: tb/tb_multi_grant_selector.sv
// Self-checking bench for multi_grant_selector at WIDTH=8, REQS=3.
module tb_multi_grant_selector;

   localparam int unsigned W = 8;
   localparam int unsigned R = 3;
   localparam int unsigned B = 3;

   typedef struct packed {
      logic [R-1:0][W-1:0] bus;
      logic [R-1:0][B-1:0] idx;
      logic [R-1:0]        valid;
      logic [W-1:0]        gnt;
      logic                empty;
   } exp_t;

   typedef struct packed {
      logic [R-1:0][B-1:0] idx;
      logic [R-1:0]        valid;
   } reg_t;

   logic                clock = 1'b0;
   logic                reset;
   logic [W-1:0]        req;
   logic [W-1:0]        gnt;
   logic [R-1:0][W-1:0] gnt_bus;
   logic [R-1:0][B-1:0] gnt_idx;
   logic [R-1:0]        gnt_valid;
   logic                empty;
   logic [R-1:0][B-1:0] gnt_idx_q;
   logic [R-1:0]        gnt_valid_q;

   int   n_checks = 0;
   int   n_fail   = 0;
   reg_t sb[$];

   always #5 clock = ~clock;

   multi_grant_selector #(
      .WIDTH (W),
      .REQS  (R)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .gnt         (gnt),
      .gnt_bus     (gnt_bus),
      .gnt_idx     (gnt_idx),
      .gnt_valid   (gnt_valid),
      .empty       (empty),
      .gnt_idx_q   (gnt_idx_q),
      .gnt_valid_q (gnt_valid_q)
   );

   // Reference: walk bits from 0 upward, filling slots in order
   function automatic exp_t model(input logic [W-1:0] r);
      exp_t e;
      int   k;
      e = '0;
      k = 0;
      for (int i = 0; i < W; i++) begin
         if (r[i] && k < R) begin
            e.bus[k][i] = 1'b1;
            e.idx[k]    = B'(i);
            e.valid[k]  = 1'b1;
            e.gnt[i]    = 1'b1;
            k++;
         end
      end
      e.empty = (r == '0);
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      req   = 8'h00;
      @(posedge clock); #1;
      n_checks++;
      if ({gnt_idx_q, gnt_valid_q} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_regs: got %h, expected 000", {gnt_idx_q, gnt_valid_q});
      end
      // Combinational path keeps tracking req while reset is held
      req = 8'hB4; #1;
      n_checks++;
      if (gnt !== 8'h34) begin
         n_fail++;
         $display("FAIL reset_comb_gnt: got %h, expected 34", gnt);
      end
      @(posedge clock); #1;
      n_checks++;
      if ({gnt_idx_q, gnt_valid_q} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_hold: got %h, expected 000", {gnt_idx_q, gnt_valid_q});
      end
   endtask

   task automatic test_empty();
      reg_t x;
      reset = 1'b0;
      req   = 8'h00; #1;
      n_checks++;
      if ({empty, gnt, gnt_valid, gnt_idx, gnt_bus} !== {1'b1, 8'h00, 3'b000, 9'h000, 24'h0}) begin
         n_fail++;
         $display("FAIL empty_comb: got e=%b g=%h v=%b i=%h", empty, gnt, gnt_valid, gnt_idx);
      end
      sb.push_back('{idx: 9'h000, valid: 3'b000});
      @(posedge clock); #1;
      x = sb.pop_front();
      n_checks++;
      if ({gnt_idx_q, gnt_valid_q} !== {x.idx, x.valid}) begin
         n_fail++;
         $display("FAIL empty_reg: got %h, expected %h", {gnt_idx_q, gnt_valid_q}, x);
      end
   endtask

   task automatic test_patterns();
      logic [W-1:0]        pr [4];
      logic [R-1:0][W-1:0] pb [4];
      logic [R-1:0][B-1:0] pi [4];
      logic [R-1:0]        pv [4];
      logic [W-1:0]        pg [4];
      reg_t                x;
      pr = '{8'hB4, 8'h81, 8'hFF, 8'h80};
      pb = '{{8'h20, 8'h10, 8'h04}, {8'h00, 8'h80, 8'h01},
             {8'h04, 8'h02, 8'h01}, {8'h00, 8'h00, 8'h80}};
      pi = '{{3'd5, 3'd4, 3'd2}, {3'd0, 3'd7, 3'd0}, {3'd2, 3'd1, 3'd0}, {3'd0, 3'd0, 3'd7}};
      pv = '{3'b111, 3'b011, 3'b111, 3'b001};
      pg = '{8'h34, 8'h81, 8'h07, 8'h80};
      reset = 1'b0;
      for (int p = 0; p < 4; p++) begin
         req = pr[p]; #1;
         n_checks++;
         if (gnt_bus !== pb[p]) begin
            n_fail++;
            $display("FAIL pat%0d_bus: got %h, expected %h", p, gnt_bus, pb[p]);
         end
         n_checks++;
         if (gnt_idx !== pi[p]) begin
            n_fail++;
            $display("FAIL pat%0d_idx: got %h, expected %h", p, gnt_idx, pi[p]);
         end
         n_checks++;
         if ({gnt_valid, gnt, empty} !== {pv[p], pg[p], 1'b0}) begin
            n_fail++;
            $display("FAIL pat%0d_vge: got v=%b g=%h e=%b, expected v=%b g=%h e=0",
                     p, gnt_valid, gnt, empty, pv[p], pg[p]);
         end
         sb.push_back('{idx: pi[p], valid: pv[p]});
         @(posedge clock); #1;
         x = sb.pop_front();
         n_checks++;
         if ({gnt_idx_q, gnt_valid_q} !== {x.idx, x.valid}) begin
            n_fail++;
            $display("FAIL pat%0d_reg: got %h, expected %h", p, {gnt_idx_q, gnt_valid_q}, x);
         end
      end
   endtask

   task automatic test_reset_mid();
      reg_t x;
      reset = 1'b0;
      req   = 8'h80;
      sb.push_back('{idx: {3'd0, 3'd0, 3'd7}, valid: 3'b001});
      @(posedge clock); #1;
      x = sb.pop_front();
      n_checks++;
      if ({gnt_idx_q, gnt_valid_q} !== {x.idx, x.valid}) begin
         n_fail++;
         $display("FAIL mid_before: got %h, expected %h", {gnt_idx_q, gnt_valid_q}, x);
      end
      reset = 1'b1;
      req   = 8'hFF; #1;
      n_checks++;
      if (gnt_idx !== {3'd2, 3'd1, 3'd0}) begin
         n_fail++;
         $display("FAIL mid_comb_idx: got %h, expected 088", gnt_idx);
      end
      sb.push_back('{idx: 9'h000, valid: 3'b000});
      @(posedge clock); #1;
      x = sb.pop_front();
      n_checks++;
      if ({gnt_idx_q, gnt_valid_q} !== {x.idx, x.valid}) begin
         n_fail++;
         $display("FAIL mid_cleared: got %h, expected %h", {gnt_idx_q, gnt_valid_q}, x);
      end
      reset = 1'b0;
      sb.push_back('{idx: {3'd2, 3'd1, 3'd0}, valid: 3'b111});
      @(posedge clock); #1;
      x = sb.pop_front();
      n_checks++;
      if ({gnt_idx_q, gnt_valid_q} !== {x.idx, x.valid}) begin
         n_fail++;
         $display("FAIL mid_reload: got %h, expected %h", {gnt_idx_q, gnt_valid_q}, x);
      end
   endtask

   task automatic test_random();
      exp_t       e;
      reg_t       x;
      logic [W-1:0] r;
      reset = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         // Mix dense and sparse request vectors
         unique case (n % 3)
            0:       r = W'($urandom);
            1:       r = W'($urandom & $urandom);
            default: r = W'($urandom & $urandom & $urandom);
         endcase
         req = r; #1;
         e = model(r);
         n_checks++;
         if (gnt_bus !== e.bus) begin
            n_fail++;
            $display("FAIL rnd_bus req=%h: got %h, expected %h", r, gnt_bus, e.bus);
         end
         n_checks++;
         if (gnt_idx !== e.idx) begin
            n_fail++;
            $display("FAIL rnd_idx req=%h: got %h, expected %h", r, gnt_idx, e.idx);
         end
         n_checks++;
         if ({gnt_valid, gnt, empty} !== {e.valid, e.gnt, e.empty}) begin
            n_fail++;
            $display("FAIL rnd_vge req=%h: got v=%b g=%h e=%b, expected v=%b g=%h e=%b",
                     r, gnt_valid, gnt, empty, e.valid, e.gnt, e.empty);
         end
         sb.push_back('{idx: e.idx, valid: e.valid});
         @(posedge clock); #1;
         x = sb.pop_front();
         n_checks++;
         if ({gnt_idx_q, gnt_valid_q} !== {x.idx, x.valid}) begin
            n_fail++;
            $display("FAIL rnd_reg req=%h: got %h, expected %h", r, {gnt_idx_q, gnt_valid_q}, x);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      test_reset();
      test_empty();
      test_patterns();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
